// File: rtl/dm_hart_rstctrl.sv
// Reset sequencer between the debug module and a set of harts: global
// hold/ack/staggered release plus independent per-hart resets.
module dm_hart_rstctrl #(
    parameter int NrHarts       = 1,
    parameter int HoldCycles    = 4,
    parameter int StaggerCycles = 0
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               testmode_i,
    input  logic               ndmreset_i,
    output logic               ndmreset_ack_o,
    input  logic [NrHarts-1:0] hartreset_i,
    input  logic [NrHarts-1:0] hart_en_i,
    output logic [NrHarts-1:0] hart_rst_no,
    output logic               busy_o
);

    localparam int HW = $clog2(HoldCycles) + 1;
    localparam int SW = $clog2(StaggerCycles) + 1;
    localparam int IW = (NrHarts > 1) ? $clog2(NrHarts) : 1;

    typedef enum logic [1:0] {
        ASSERT,
        ACK,
        RELEASE,
        IDLE
    } state_e;

    state_e               state_q, state_d;
    logic [HW-1:0]        hold_q, hold_d;
    logic [SW-1:0]        stag_q, stag_d;
    logic [IW-1:0]        idx_q, idx_d;
    logic                 ivld_q, ivld_d;
    logic [NrHarts-1:0]   rel_q, rel_d;
    logic                 ack_q, ack_d;
    logic [NrHarts-1:0]   rst_q, rst_d;
    logic [HW-1:0]        cnt_q [NrHarts];
    logic [HW-1:0]        cnt_d [NrHarts];

    logic [IW-1:0]        first_idx, next_idx;
    logic                 first_vld, next_vld;
    logic                 do_rel, abort;

    // Disabled harts are skipped combinationally so they cost no cycles.
    always_comb begin
        first_idx = '0;
        first_vld = 1'b0;
        next_idx  = '0;
        next_vld  = 1'b0;
        for (int i = NrHarts - 1; i >= 0; i--) begin
            if (hart_en_i[i]) begin
                first_idx = IW'(i);
                first_vld = 1'b1;
            end
            if (hart_en_i[i] && (IW'(i) > idx_q)) begin
                next_idx = IW'(i);
                next_vld = 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        stag_d  = stag_q;
        idx_d   = idx_q;
        ivld_d  = ivld_q;
        rel_d   = rel_q;
        ack_d   = 1'b0;
        do_rel  = 1'b0;
        abort   = 1'b0;
        unique case (state_q)
            ASSERT: begin
                hold_d = hold_q + HW'(1);
                rel_d  = '0;
                idx_d  = first_idx;
                ivld_d = first_vld;
                stag_d = '0;
                if (hold_q == HW'(HoldCycles - 1)) begin
                    hold_d = '0;
                    if (ndmreset_i) begin
                        state_d = ACK;
                        ack_d   = 1'b1;
                    end else begin
                        state_d = RELEASE;
                    end
                end
            end
            ACK: begin
                // Dropping the request releases the first hart at once.
                if (ndmreset_i) begin
                    ack_d = 1'b1;
                end else begin
                    state_d = RELEASE;
                    do_rel  = ivld_q;
                end
            end
            RELEASE: begin
                if (ndmreset_i) begin
                    abort = 1'b1;
                end else if (!ivld_q) begin
                    state_d = IDLE;
                end else if (stag_q == '0) begin
                    do_rel = 1'b1;
                end else begin
                    stag_d = stag_q - SW'(1);
                end
            end
            IDLE: begin
                abort = ndmreset_i;
            end
            default: begin
                state_d = ASSERT;
            end
        endcase
        if (abort) begin
            state_d = ASSERT;
            hold_d  = '0;
            rel_d   = '0;
        end
        if (do_rel) begin
            for (int h = 0; h < NrHarts; h++) begin
                if (IW'(h) == idx_q) rel_d[h] = 1'b1;
            end
            idx_d  = next_idx;
            ivld_d = next_vld;
            stag_d = SW'(StaggerCycles);
        end
    end

    // A hart runs only when globally released and its own hold has expired.
    always_comb begin
        cnt_d = cnt_q;
        rst_d = '0;
        for (int h = 0; h < NrHarts; h++) begin
            if (hartreset_i[h]) begin
                cnt_d[h] = HW'(HoldCycles);
            end else if (cnt_q[h] != '0) begin
                cnt_d[h] = cnt_q[h] - HW'(1);
            end
            rst_d[h] = hart_en_i[h] & rel_d[h] & ~hartreset_i[h]
                     & (cnt_q[h] == '0);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ASSERT;
            hold_q  <= '0;
            stag_q  <= '0;
            idx_q   <= '0;
            ivld_q  <= 1'b0;
            rel_q   <= '0;
            ack_q   <= 1'b0;
            rst_q   <= '0;
            for (int h = 0; h < NrHarts; h++) begin
                cnt_q[h] <= '0;
            end
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            stag_q  <= stag_d;
            idx_q   <= idx_d;
            ivld_q  <= ivld_d;
            rel_q   <= rel_d;
            ack_q   <= ack_d;
            rst_q   <= rst_d;
            for (int h = 0; h < NrHarts; h++) begin
                cnt_q[h] <= cnt_d[h];
            end
        end
    end

    assign hart_rst_no    = testmode_i ? {NrHarts{rst_ni}} : rst_q;
    assign ndmreset_ack_o = ack_q;
    assign busy_o         = (state_q != IDLE);

endmodule

// File: tb/tb_dm_hart_rstctrl.sv
// Scoreboard bench for dm_hart_rstctrl: timing-rule reference model,
// directed scenarios followed by randomized ndmreset/hartreset traffic.
module tb_dm_hart_rstctrl;

    localparam int N = 4;
    localparam int H = 4;
    localparam int S = 2;

    localparam int P_HOLD = 0;
    localparam int P_ACK  = 1;
    localparam int P_REL  = 2;
    localparam int P_IDLE = 3;

    logic         clk = 1'b0;
    logic         rst_ni = 1'b0;
    logic         testmode = 1'b0;
    logic         ndm = 1'b0;
    logic [N-1:0] hr = '0;
    logic [N-1:0] en = '1;
    logic         ack;
    logic         busy;
    logic [N-1:0] hrn;

    always #5 clk = ~clk;

    dm_hart_rstctrl #(
        .NrHarts       (N),
        .HoldCycles    (H),
        .StaggerCycles (S)
    ) dut (
        .clk_i          (clk),
        .rst_ni         (rst_ni),
        .testmode_i     (testmode),
        .ndmreset_i     (ndm),
        .ndmreset_ack_o (ack),
        .hartreset_i    (hr),
        .hart_en_i      (en),
        .hart_rst_no    (hrn),
        .busy_o         (busy)
    );

    typedef struct packed {
        logic [N-1:0] rst;
        logic         ack;
        logic         busy;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = -3;

    // Reference model: phase plus the edge times at which things happen.
    int           ph;
    int           seq_start;
    int           rel_base;
    int           rel_enter;
    int           last_hr [N];
    logic [N-1:0] m_rst;
    logic         m_ack;
    logic         m_busy;

    function automatic int rank_of(int h);
        int k = 0;
        for (int i = 0; i < h; i++) if (en[i]) k++;
        return k;
    endfunction

    task automatic model_reset();
        ph = P_HOLD;
        seq_start = cyc;
        for (int i = 0; i < N; i++) last_hr[i] = -1000;
        m_rst  = '0;
        m_ack  = 1'b0;
        m_busy = 1'b1;
    endtask

    task automatic model_edge();
        int e;
        int n;
        int idle_at;
        bit glob;
        e = cyc;
        n = $countones(en);
        if (!rst_ni) return;
        if ((ph == P_REL || ph == P_IDLE) && ndm) begin
            ph = P_HOLD;
            seq_start = e;
        end else if (ph == P_HOLD && e == seq_start + H) begin
            if (ndm) begin
                ph = P_ACK;
            end else begin
                ph = P_REL;
                rel_enter = e;
                rel_base = e + 1;
            end
        end else if (ph == P_ACK && !ndm) begin
            ph = P_REL;
            rel_enter = e;
            rel_base = e;
        end
        if (ph == P_REL) begin
            idle_at = (n > 0) ? rel_base + (n - 1) * (S + 1) + 1
                              : rel_enter + 1;
            if (e >= idle_at) ph = P_IDLE;
        end
        for (int h = 0; h < N; h++) begin
            if (hr[h]) last_hr[h] = e;
            glob = (ph == P_IDLE) ||
                   (ph == P_REL && e >= rel_base + rank_of(h) * (S + 1));
            m_rst[h] = en[h] && glob && !hr[h] && (e >= last_hr[h] + H + 1);
        end
        m_ack  = (ph == P_ACK);
        m_busy = (ph != P_IDLE);
    endtask

    task automatic push();
        exp_t x;
        x.rst  = testmode ? {N{rst_ni}} : m_rst;
        x.ack  = m_ack;
        x.busy = m_busy;
        q.push_back(x);
    endtask

    task automatic rst_assert();
        rst_ni = 1'b0;
        model_reset();
    endtask

    task automatic rst_release();
        rst_ni = 1'b1;
        seq_start = cyc;
    endtask

    task automatic directed();
        case (cyc)
            0:   rst_release();
            20:  ndm = 1'b1;
            30:  ndm = 1'b0;
            35:  ndm = 1'b1;
            40:  ndm = 1'b0;
            60:  hr[2] = 1'b1;
            62:  hr[2] = 1'b0;
            70:  begin hr[0] = 1'b1; ndm = 1'b1; end
            80:  ndm = 1'b0;
            82:  hr[0] = 1'b0;
            100: begin rst_assert(); en = 4'b1010; end
            102: rst_release();
            115: ndm = 1'b1;
            125: ndm = 1'b0;
            140: testmode = 1'b1;
            142: rst_assert();
            144: rst_release();
            146: rst_assert();
            147: begin testmode = 1'b0; en = 4'b1111; end
            148: rst_release();
            default: ;
        endcase
    endtask

    task automatic random_stim();
        if (!rst_ni) begin
            rst_release();
        end else if ($urandom_range(0, 599) == 0) begin
            rst_assert();
            en = N'($urandom_range(0, 15));
        end else begin
            if (ndm) begin
                if ($urandom_range(0, 7) == 0) ndm = 1'b0;
            end else if ($urandom_range(0, 59) == 0) begin
                ndm = 1'b1;
            end
            for (int h = 0; h < N; h++) begin
                if (hr[h]) begin
                    if ($urandom_range(0, 2) == 0) hr[h] = 1'b0;
                end else if ($urandom_range(0, 39) == 0) begin
                    hr[h] = 1'b1;
                end
            end
        end
    endtask

    exp_t x_mon;
    exp_t d_mon;
    bit   hit;

    always @(negedge clk) begin
        if (q.size() > 0) begin
            x_mon = q.pop_front();
            checks++;
            if ({hrn, ack, busy} !== x_mon) begin
                errors++;
                $display("FAIL outputs cyc %0d: rst=%b ack=%b busy=%b, required rst=%b ack=%b busy=%b",
                         cyc, hrn, ack, busy, x_mon.rst, x_mon.ack, x_mon.busy);
            end
            hit = 1'b1;
            case (cyc)
                5:   d_mon = {4'b0001, 1'b0, 1'b1};
                8:   d_mon = {4'b0011, 1'b0, 1'b1};
                11:  d_mon = {4'b0111, 1'b0, 1'b1};
                14:  d_mon = {4'b1111, 1'b0, 1'b1};
                15:  d_mon = {4'b1111, 1'b0, 1'b0};
                21:  d_mon = {4'b0000, 1'b0, 1'b1};
                24:  d_mon = {4'b0000, 1'b0, 1'b1};
                25:  d_mon = {4'b0000, 1'b1, 1'b1};
                31:  d_mon = {4'b0001, 1'b0, 1'b1};
                34:  d_mon = {4'b0011, 1'b0, 1'b1};
                36:  d_mon = {4'b0000, 1'b0, 1'b1};
                40:  d_mon = {4'b0000, 1'b1, 1'b1};
                41:  d_mon = {4'b0001, 1'b0, 1'b1};
                50:  d_mon = {4'b1111, 1'b0, 1'b1};
                51:  d_mon = {4'b1111, 1'b0, 1'b0};
                61:  d_mon = {4'b1011, 1'b0, 1'b0};
                66:  d_mon = {4'b1011, 1'b0, 1'b0};
                67:  d_mon = {4'b1111, 1'b0, 1'b0};
                107: d_mon = {4'b0010, 1'b0, 1'b1};
                110: d_mon = {4'b1010, 1'b0, 1'b1};
                111: d_mon = {4'b1010, 1'b0, 1'b0};
                116: d_mon = {4'b0000, 1'b0, 1'b1};
                120: d_mon = {4'b0000, 1'b1, 1'b1};
                126: d_mon = {4'b0010, 1'b0, 1'b1};
                129: d_mon = {4'b1010, 1'b0, 1'b1};
                130: d_mon = {4'b1010, 1'b0, 1'b0};
                140: d_mon = {4'b1111, 1'b0, 1'b0};
                142: d_mon = {4'b0000, 1'b0, 1'b1};
                144: d_mon = {4'b1111, 1'b0, 1'b1};
                default: begin
                    hit = 1'b0;
                    d_mon = '0;
                end
            endcase
            if (hit) begin
                checks++;
                if ({hrn, ack, busy} !== d_mon) begin
                    errors++;
                    $display("FAIL directed cyc %0d: rst=%b ack=%b busy=%b, required rst=%b ack=%b busy=%b",
                             cyc, hrn, ack, busy, d_mon.rst, d_mon.ack, d_mon.busy);
                end
            end
        end
    end

    initial begin
        model_reset();
        for (int c = 0; c < 3200; c++) begin
            @(posedge clk);
            cyc++;
            model_edge();
            #1;
            if (cyc < 150) directed();
            else random_stim();
            push();
        end
        @(negedge clk);
        #1;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d entries left, required 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dm_hart_rstctrl.md
# dm_hart_rstctrl

Parametrised reset sequencer between the debug module and the harts of a multi-hart test environment. It replaces the single-hart pairing of reset generator and one-cycle `ndmreset` acknowledge. It holds all harts in reset for a guaranteed minimum time on power-on or `ndmreset`, and acknowledges the request to the DM. It then releases enabled harts in ascending index order with a programmable stagger, and handles independent per-hart resets.

## Interface
Parameters:
- `NrHarts`, 1, number of controlled harts (1..32).
- `HoldCycles`, 4, minimum cycles every hart is held in reset (>=1).
- `StaggerCycles`, 0, idle cycles between consecutive hart releases (0 = all enabled harts released together).

Ports:
- `clk_i`  in  1  clock.
- `rst_ni`  in  1  reset, asynchronous, active-low; clock `clk_i`.
- `testmode_i`  in  1  scan bypass: `hart_rst_no` = `rst_ni` for every hart.
- `ndmreset_i`  in  1  non-debug-module reset request from the DM, level.
- `ndmreset_ack_o`  out  1  acknowledge to the DM, level.
- `hartreset_i`  in  NrHarts  per-hart reset request, level.
- `hart_en_i`  in  NrHarts  hart present; a 0 keeps that hart in reset permanently; quasi-static.
- `hart_rst_no`  out  NrHarts  per-hart reset, active-low, registered.
- `busy_o`  out  1  high in any state other than IDLE.

## Operation
- FSM states: ASSERT, ACK, RELEASE, IDLE. `hold_cnt` and `stag_cnt` are sized to `$clog2` of their max value plus 1. `idx` is the next-hart pointer.
- Reset values (rst_ni low):
  - state ASSERT, `hold_cnt` 0;
  - `hart_rst_no` all 0, `ndmreset_ack_o` 0, `busy_o` 1;
  - all per-hart hold counters 0.
- ASSERT:
  - All `hart_rst_no` = 0; `hold_cnt` increments each cycle.
  - When `hold_cnt` = HoldCycles-1: go to ACK if `ndmreset_i` = 1, else go to RELEASE.
- ACK:
  - `ndmreset_ack_o` = 1; harts stay in reset.
  - On `ndmreset_i` = 0: go to RELEASE, ack drops.
- RELEASE:
  - On entry, `idx` = lowest enabled hart and `stag_cnt` = 0.
  - When `stag_cnt` = 0: set `hart_rst_no[idx]` = 1, unless that hart's `hartreset_i` or hold counter is active, in which case the per-hart path releases it later. Then advance `idx` to the next enabled index (found combinationally, so disabled harts cost no cycles) and reload `stag_cnt` = StaggerCycles.
  - Otherwise decrement `stag_cnt`.
  - When no enabled hart remains: go to IDLE.
  - If no hart is enabled at all: go RELEASE -> IDLE in one cycle.
- IDLE:
  - `busy_o` = 0.
  - Per-hart path: `hartreset_i[h]` = 1 drives `hart_rst_no[h]` = 0 and loads that hart's counter with HoldCycles.
  - After `hartreset_i[h]` falls, the counter decrements. `hart_rst_no[h]` returns to 1 the cycle after it reaches 0.
  - Per-hart reset never touches `ndmreset_ack_o` or other harts.
- Disabled harts (`hart_en_i` = 0): `hart_rst_no` = 0 in every state.
- `ndmreset_i` rising in any state other than ASSERT or ACK (RELEASE or IDLE): next cycle all `hart_rst_no` = 0, state ASSERT, `hold_cnt` = 0. Partially released harts are re-asserted.
- `ndmreset_i` falling during ASSERT: the hold still completes, then RELEASE is entered with no ack.
- `hartreset_i` asserted during a global sequence: that hart stays in reset until both the global sequence and its own hold counter release it.
- `rst_ni` assertion mid-sequence: immediate asynchronous return to reset values; the power-on sequence then runs (ASSERT -> RELEASE).

## Timing
- All outputs registered except in `testmode_i`.
- `ndmreset_i` sampled high at edge N (state IDLE): `hart_rst_no` = 0 and `busy_o` = 1 from edge N+1.
- `ndmreset_ack_o` = 1 from edge N+1+HoldCycles.
- `ndmreset_i` sampled low at edge M (state ACK): `ndmreset_ack_o` = 0 from M+1, and the first enabled hart is released at M+1.
- Release k (0-based, k-th enabled hart) occurs at M+1+k*(StaggerCycles+1).
- `busy_o` = 0 one cycle after the last release.
- Power-on: first hart released HoldCycles+1 cycles after `rst_ni` deasserts, with `ndmreset_i` low.
- Per-hart: `hartreset_i` sampled high at edge P gives `hart_rst_no[h]` low at P+1. Sampled low at edge Q gives high at Q+1+HoldCycles.

## Test plan
Parameters for all scenarios: NrHarts=4, HoldCycles=4, StaggerCycles=2, `hart_en_i`=4'b1111 unless stated.
- Power-on: `rst_ni` released at cycle 0 -> `hart_rst_no` 0001, 0011, 0111, 1111 at cycles 5, 8, 11, 14; `busy_o` low at cycle 15; `ndmreset_ack_o` stays 0.
- ndmreset: `ndmreset_i` high at cycle 20, low at 30 -> `hart_rst_no` 0000 at cycle 21; ack high cycles 25-30; releases at 31/34/37/40.
- Abort: `ndmreset_i` re-asserted at cycle 35 during RELEASE -> `hart_rst_no` 0000 at 36; ack high again at 40.
- Disabled hart: `hart_en_i`=1010 -> releases at M+1 (hart 1) and M+4 (hart 3); harts 0 and 2 stay 0 throughout.
- Per-hart: `hartreset_i[2]` high cycles 50-52 in IDLE -> `hart_rst_no[2]` low cycles 51-56, others stay 1, ack stays 0.
- testmode: `testmode_i`=1, `rst_ni` toggled -> all `hart_rst_no` follow `rst_ni` combinationally.
